// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises the serial line, recovers each byte with a
// mid-bit sampling FSM and hands it out on a valid/ready interface with overrun tracking.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 2500,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    state_t                 state_r;
    logic [CNT_W-1:0]       baud_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;

    logic rxs_s;
    logic bit_end_s;
    logic xfer_s;
    logic good_stop_s;

    assign rxs_s       = sync_r[SYNC_STAGES-1];
    assign bit_end_s   = (baud_cnt_r == BIT_M1);
    assign xfer_s      = rx_valid & rx_ready;
    assign good_stop_s = (state_r == ST_STOP) & bit_end_s & rxs_s;

    // Metastability synchroniser; reset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_rx};
        end
    end

    // Receive FSM: start validation, data shifting, stop check and break recovery
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= CNT_ZERO;
                    bit_idx_r  <= 3'd0;
                    if (!rxs_s) begin
                        state_r <= ST_START;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that is gone by mid-bit is treated as a glitch
                    if (baud_cnt_r == HALF_M1) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (rxs_s) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            busy    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        shift_r    <= {rxs_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= ST_STOP;
                            bit_idx_r <= 3'd0;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (rxs_s) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r   <= ST_WAIT_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_IDLE: begin
                    baud_cnt_r <= CNT_ZERO;
                    if (rxs_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= CNT_ZERO;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register, handshake and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (good_stop_s) begin
            // A byte consumed in the same cycle is not an overrun
            rx_data  <= shift_r;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ready;
        end else if (xfer_s) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_valid <= rx_valid;
            overrun  <= overrun;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: fast instance (16 clks/bit) for functional
// cases and a 2500 clks/bit instance for the transmitter-rate frame spacing.
module tb_uart_rx_frame;

    localparam int CPB_A = 16;
    localparam int CPB_B = 2500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_a = 1'b1, ready_a = 1'b0;
    logic       line_b = 1'b1, ready_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, ferr_b, ovr_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt_a = 0;
    int ferr_cnt_b = 0;
    int f0;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_frame #(.CLKS_PER_BIT(CPB_A), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .line_rx(line_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB_B), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .line_rx(line_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [9:0] fr(input logic [7:0] d, input logic stop_bit);
        return {stop_bit, d, 1'b0};
    endfunction

    task automatic send_frame(input bit on_b, input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (on_b) line_b = frame[i];
            else      line_a = frame[i];
            tick(on_b ? CPB_B : CPB_A);
        end
    endtask

    // Monitor: pops the expected {overrun, data} on every transfer
    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (!rst) begin
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_byte", data_a, 8'hxx);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", data_a, e[7:0]);
                    check("a_overrun", {7'd0, ovr_a}, {7'd0, e[8]});
                end
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_byte", data_b, 8'hxx);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", data_b, e[7:0]);
                    check("b_overrun", {7'd0, ovr_b}, {7'd0, e[8]});
                end
            end
            if (ferr_a) ferr_cnt_a++;
            if (ferr_b) ferr_cnt_b++;
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_data", data_a, 8'h00);
        check("rst_valid", {7'd0, valid_a}, 8'd0);
        check("rst_ferr", {7'd0, ferr_a}, 8'd0);
        check("rst_ovr", {7'd0, ovr_a}, 8'd0);
        check("rst_busy", {7'd0, busy_a}, 8'd0);
        check("rst_busy_b", {7'd0, busy_b}, 8'd0);

        // Two back-to-back frames consumed immediately
        ready_a = 1'b1;
        q_a.push_back({1'b0, 8'h47});
        q_a.push_back({1'b0, 8'h30});
        send_frame(1'b0, fr(8'h47, 1'b1), 10);
        send_frame(1'b0, fr(8'h30, 1'b1), 10);
        tick(2 * CPB_A);
        check("t1_drained", 8'(q_a.size()), 8'd0);
        check("t1_no_ferr", 8'(ferr_cnt_a), 8'd0);

        // Overrun: second byte overwrites the unconsumed first
        ready_a = 1'b0;
        send_frame(1'b0, fr(8'hA5, 1'b1), 10);
        send_frame(1'b0, fr(8'h3C, 1'b1), 10);
        tick(CPB_A);
        check("t2_data", data_a, 8'h3C);
        check("t2_valid", {7'd0, valid_a}, 8'd1);
        check("t2_ovr", {7'd0, ovr_a}, 8'd1);
        q_a.push_back({1'b1, 8'h3C});
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        check("t2_valid_clr", {7'd0, valid_a}, 8'd0);
        check("t2_ovr_clr", {7'd0, ovr_a}, 8'd0);
        check("t2_drained", 8'(q_a.size()), 8'd0);

        // Framing error followed by a break, then a good frame
        ready_a = 1'b1;
        f0 = ferr_cnt_a;
        send_frame(1'b0, fr(8'h55, 1'b0), 10);
        line_a = 1'b0;
        tick(20 * CPB_A);
        check("t3_busy_break", {7'd0, busy_a}, 8'd1);
        check("t3_valid_break", {7'd0, valid_a}, 8'd0);
        tick(20 * CPB_A);
        line_a = 1'b1;
        tick(2 * CPB_A);
        check("t3_busy_idle", {7'd0, busy_a}, 8'd0);
        check("t3_ferr_once", 8'(ferr_cnt_a - f0), 8'd1);
        check("t3_valid", {7'd0, valid_a}, 8'd0);
        q_a.push_back({1'b0, 8'h12});
        send_frame(1'b0, fr(8'h12, 1'b1), 10);
        tick(2 * CPB_A);
        check("t3_drained", 8'(q_a.size()), 8'd0);

        // Short low glitch on an idle line
        f0 = ferr_cnt_a;
        line_a = 1'b0;
        tick(3);
        line_a = 1'b1;
        check("t4_busy_start", {7'd0, busy_a}, 8'd1);
        tick(8);
        check("t4_busy_back", {7'd0, busy_a}, 8'd0);
        check("t4_valid", {7'd0, valid_a}, 8'd0);
        check("t4_no_ferr", 8'(ferr_cnt_a - f0), 8'd0);

        // Reset in the middle of data bit 4 of 0xFF
        send_frame(1'b0, fr(8'hFF, 1'b1), 5);
        line_a = 1'b1;
        tick(CPB_A / 2);
        check("t5_busy_pre", {7'd0, busy_a}, 8'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_data", data_a, 8'h00);
        check("t5_valid", {7'd0, valid_a}, 8'd0);
        check("t5_busy", {7'd0, busy_a}, 8'd0);
        check("t5_ovr", {7'd0, ovr_a}, 8'd0);
        check("t5_ferr", {7'd0, ferr_a}, 8'd0);
        tick(6 * CPB_A);
        check("t5_no_byte", {7'd0, valid_a}, 8'd0);
        q_a.push_back({1'b0, 8'h81});
        send_frame(1'b0, fr(8'h81, 1'b1), 10);
        tick(2 * CPB_A);
        check("t5_drained", 8'(q_a.size()), 8'd0);

        // Transmitter-rate frames with one idle bit either side
        ready_b = 1'b1;
        q_b.push_back({1'b0, 8'h47});
        q_b.push_back({1'b0, 8'h30});
        tick(CPB_B);
        send_frame(1'b1, fr(8'h47, 1'b1), 10);
        tick(2 * CPB_B);
        send_frame(1'b1, fr(8'h30, 1'b1), 10);
        tick(CPB_B);
        check("t6_drained", 8'(q_b.size()), 8'd0);
        check("t6_no_ferr", 8'(ferr_cnt_b), 8'd0);
        check("t6_ovr", {7'd0, ovr_b}, 8'd0);
        check("t6_busy", {7'd0, busy_b}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
